seletor_num: RTL and testbench
==============================

Name: seletor_num

Overview:
- Upstream stage of decodificador_num: produces the 3-bit digit select (sel) and a display-blank flag from three raw push buttons.
- Lets the user step a value 0..7 up or down, confirm it, and show it steadily.
- The digit blinks while editing.
- The top level forces all segments off when blank=1.

Parameters:
DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change
BLINK_DIV, 25000000, clk cycles per blink half-period
TIMEOUT_BLINKS, 16, full blink periods without an accepted press before EDIT falls back to IDLE

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
btn_up  input  1  raw button, active-low (0 = pressed)
btn_down  input  1  raw button, active-low
btn_ok  input  1  raw button, active-low
sel  output  3  digit to decodificador_num.sel
blank  output  1  1 = display off
value  output  3  last confirmed digit
confirmed  output  1  one-cycle pulse when a value is confirmed

Behaviour:
- Reset (async, all registers):
  - sel=0, value=0, blank=1, confirmed=0, state=IDLE.
  - Synchronizer FFs and debounced levels = 1 (released).
  - All counters = 0; blink phase = 0.
- Input conditioning, per button:
  - 2-FF synchronizer (s1, s2).
  - Debounce counter increments while s2 != deb and clears when s2 == deb.
  - When the counter = DEB_CYCLES-1 and s2 != deb: deb <= s2, counter <= 0, and a press event is registered if the new level is 0.
  - Press event is a one-cycle pulse on the edge deb falls; release produces no event.
  - Timing from raw low held from edge 0: deb low after edge 2+DEB_CYCLES; event visible the following cycle; FSM outputs update at edge 3+DEB_CYCLES.
- Blink:
  - Counter runs 0..BLINK_DIV-1 and wraps; phase toggles on wrap.
  - Counter and phase clear (digit visible) on entering EDIT and on every accepted up/down event.
- States:
  - IDLE: blank=1; sel holds its value. Any press event -> EDIT, sel unchanged (wake only, no step).
  - EDIT: blank=phase.
    - up: sel <= sel+1, 7 wraps to 0.
    - down: sel <= sel-1, 0 wraps to 7.
    - up and down in the same cycle: no change, treated as no press.
    - ok: value <= sel, confirmed=1 for one cycle, -> SHOW. ok has priority over up/down in the same cycle.
    - Timeout counter counts phase toggles and clears on entry and on any press event. Reaching 2*TIMEOUT_BLINKS -> IDLE, value unchanged.
  - SHOW: blank=0, sel=value.
    - up or down -> EDIT with sel=value, no step.
    - ok -> IDLE.
- confirmed is registered and asserted only on the SHOW entry cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- Buttons held indefinitely produce one event only; no auto-repeat.
- Reset mid-debounce or mid-EDIT discards all pending state immediately.

Test Plan:
Use DEB_CYCLES=3, BLINK_DIV=4, TIMEOUT_BLINKS=2.
1. Reset, then release reset with all buttons at 1 -> sel=0, value=0, blank=1, confirmed=0; hold 50 cycles with no change.
2. Pulse btn_up low for 2 cycles (a glitch shorter than DEB_CYCLES) -> no event, state stays IDLE, blank=1. Then hold btn_up low -> EDIT exactly at edge 6, sel=0, blank=0.
3. In EDIT, press down once -> sel=7 (wrap). Press up twice -> sel=1. Press up and down in the same cycle -> sel stays 1.
4. In EDIT with sel=5, press ok -> value=5; confirmed high exactly one cycle; SHOW with blank=0 steady for 40 cycles. Press up -> EDIT with sel=5.
5. In EDIT, no presses -> blank toggles every 4 cycles; after 4 toggles (16 cycles) -> IDLE, blank=1, value unchanged.
6. Assert reset while in EDIT with sel=3 and btn_up held -> outputs return to reset values in the same cycle. After release with btn_up still held low -> one event (wake only, sel=0), no repeat.

Source files
------------

// File: rtl/seletor_num.sv
// Debounces three push buttons and runs an IDLE/EDIT/SHOW selector for a 0..7 digit with a blink-while-editing flag.
// Press-to-output latency is DEB_CYCLES+3 clocks. All outputs are registered, and the block applies no backpressure.
module seletor_num #(
  parameter int DEB_CYCLES     = 500000,
  parameter int BLINK_DIV      = 25000000,
  parameter int TIMEOUT_BLINKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  output logic [2:0] sel,
  output logic       blank,
  output logic [2:0] value,
  output logic       confirmed
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (2 * TIMEOUT_BLINKS > 1) ? $clog2(2 * TIMEOUT_BLINKS) : 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TOUT_LAST  = TW'(2 * TIMEOUT_BLINKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EDIT = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;

  logic [2:0]    raw, s1, s2, deb, evt;
  logic [DW-1:0] dcnt [3];

  assign raw = {btn_ok, btn_down, btn_up};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= '1;
      s2  <= '1;
      deb <= '1;
      evt <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        evt[i] <= 1'b0;
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
          evt[i]  <= ~s2[i];  // only the falling (press) edge is an event
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  logic          up_e, dn_e, ok_e, step, wrap;
  logic [1:0]    state, state_n;
  logic [2:0]    sel_n, value_n;
  logic          conf_n, blank_n, phase, phase_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;

  assign up_e = evt[0];
  assign dn_e = evt[1];
  assign ok_e = evt[2];
  assign step = up_e ^ dn_e;
  assign wrap = (bcnt == BLINK_LAST);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    value_n = value;
    conf_n  = 1'b0;
    bcnt_n  = wrap ? '0 : bcnt + BW'(1);
    phase_n = phase ^ wrap;
    tcnt_n  = tcnt;
    case (state)
      IDLE: begin
        if (|evt) begin
          state_n = EDIT;
          bcnt_n  = '0;
          phase_n = 1'b0;
          tcnt_n  = '0;
        end
      end
      EDIT: begin
        if (ok_e) begin
          state_n = SHOW;
          value_n = sel;
          conf_n  = 1'b1;
        end else if (step) begin
          sel_n   = up_e ? sel + 3'd1 : sel - 3'd1;
          bcnt_n  = '0;
          phase_n = 1'b0;
          tcnt_n  = '0;
        end else if (wrap) begin
          if (tcnt == TOUT_LAST) begin
            state_n = IDLE;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      SHOW: begin
        sel_n = value;
        if (ok_e) begin
          state_n = IDLE;
        end else if (up_e || dn_e) begin
          state_n = EDIT;
          bcnt_n  = '0;
          phase_n = 1'b0;
          tcnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // blank is derived from next-state so it lands in the same cycle as the transition
    if (state_n == SHOW)      blank_n = 1'b0;
    else if (state_n == EDIT) blank_n = phase_n;
    else                      blank_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 3'd0;
      value     <= 3'd0;
      blank     <= 1'b1;
      confirmed <= 1'b0;
      bcnt      <= '0;
      phase     <= 1'b0;
      tcnt      <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      value     <= value_n;
      blank     <= blank_n;
      confirmed <= conf_n;
      bcnt      <= bcnt_n;
      phase     <= phase_n;
      tcnt      <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_seletor_num.sv
// Directed bench for seletor_num with DEB_CYCLES=3, BLINK_DIV=4, TIMEOUT_BLINKS=2.
// Inputs change 1 time unit after a rising edge and outputs are sampled there too.
module tb_seletor_num;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b1, btn_down = 1'b1, btn_ok = 1'b1;
  logic [2:0] sel, value;
  logic       blank, confirmed;

  int total = 0;
  int bad = 0;

  seletor_num #(.DEB_CYCLES(3), .BLINK_DIV(4), .TIMEOUT_BLINKS(2)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
    .sel(sel), .blank(blank), .value(value), .confirmed(confirmed)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    tick(3);
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (value !== 3'd0) begin bad++; $display("FAIL reset_value got=%0d exp=0", value); end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b exp=1", blank); end
    total++; if (confirmed !== 1'b0) begin bad++; $display("FAIL reset_confirmed got=%b exp=0", confirmed); end
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      total++;
      if (sel !== 3'd0 || value !== 3'd0 || blank !== 1'b1 || confirmed !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d got sel=%0d value=%0d blank=%b conf=%b exp 0/0/1/0",
                 k, sel, value, blank, confirmed);
      end
    end
  endtask

  task automatic test_glitch_wake;
    btn_up = 1'b0;
    tick(2);
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      total++; if (blank !== 1'b1) begin bad++; $display("FAIL glitch_blank cyc=%0d got=%b exp=1", k, blank); end
    end
    btn_up = 1'b0;
    tick(5);
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL wake_early got blank=%b exp=1", blank); end
    tick(1);
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL wake_edge6_blank got=%b exp=0", blank); end
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL wake_sel got=%0d exp=0", sel); end
    btn_up = 1'b1;
    tick(6);
  endtask

  task automatic test_step;
    btn_down = 1'b0;
    tick(5);
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL down_early sel=%0d exp=0", sel); end
    tick(1);
    total++; if (sel !== 3'd7) begin bad++; $display("FAIL down_wrap sel=%0d exp=7", sel); end
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL down_blank got=%b exp=0", blank); end
    btn_down = 1'b1; tick(6);
    btn_up = 1'b0; tick(6);
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL up_wrap sel=%0d exp=0", sel); end
    btn_up = 1'b1; tick(6);
    btn_up = 1'b0; tick(6);
    total++; if (sel !== 3'd1) begin bad++; $display("FAIL up_one sel=%0d exp=1", sel); end
    btn_up = 1'b1; tick(6);
    btn_up = 1'b0; btn_down = 1'b0; tick(6);
    total++; if (sel !== 3'd1) begin bad++; $display("FAIL up_down_same sel=%0d exp=1", sel); end
    btn_up = 1'b1; btn_down = 1'b1; tick(10);
    // 22 cycles past the last real step: timed out unless up+down wrongly restarted the timeout
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL both_no_clear blank=%b exp=1", blank); end
    btn_up = 1'b0; tick(6);
    total++; if (sel !== 3'd1) begin bad++; $display("FAIL rewake_sel sel=%0d exp=1", sel); end
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL rewake_blank got=%b exp=0", blank); end
    btn_up = 1'b1; tick(6);
    for (int i = 2; i <= 5; i++) begin
      btn_up = 1'b0; tick(6);
      total++; if (sel !== 3'(i)) begin bad++; $display("FAIL up_to_5 sel=%0d exp=%0d", sel, i); end
      btn_up = 1'b1; tick(6);
    end
  endtask

  task automatic test_confirm;
    btn_ok = 1'b0;
    tick(5);
    total++; if (confirmed !== 1'b0) begin bad++; $display("FAIL conf_early got=%b exp=0", confirmed); end
    total++; if (value !== 3'd0) begin bad++; $display("FAIL value_before_ok got=%0d exp=0", value); end
    tick(1);
    total++; if (confirmed !== 1'b1) begin bad++; $display("FAIL conf_pulse got=%b exp=1", confirmed); end
    total++; if (value !== 3'd5) begin bad++; $display("FAIL conf_value got=%0d exp=5", value); end
    total++; if (blank !== 1'b0 || sel !== 3'd5) begin bad++; $display("FAIL show_entry blank=%b sel=%0d exp 0/5", blank, sel); end
    tick(1);
    total++; if (confirmed !== 1'b0) begin bad++; $display("FAIL conf_one_cycle got=%b exp=0", confirmed); end
    btn_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      total++;
      if (blank !== 1'b0 || confirmed !== 1'b0 || sel !== 3'd5) begin
        bad++;
        $display("FAIL show_steady cyc=%0d blank=%b conf=%b sel=%0d exp 0/0/5", k, blank, confirmed, sel);
      end
    end
    btn_up = 1'b0; tick(6);
    total++; if (sel !== 3'd5) begin bad++; $display("FAIL show_to_edit sel=%0d exp=5", sel); end
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL show_to_edit_blank got=%b exp=0", blank); end
  endtask

  task automatic test_timeout;
    logic exp_b;
    btn_up = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      exp_b = (k >= 16) ? 1'b1 : (((k / 4) % 2) == 1);
      total++; if (blank !== exp_b) begin bad++; $display("FAIL blink cyc=%0d blank=%b exp=%b", k, blank, exp_b); end
    end
    total++; if (value !== 3'd5) begin bad++; $display("FAIL timeout_value got=%0d exp=5", value); end
    total++; if (sel !== 3'd5) begin bad++; $display("FAIL timeout_sel got=%0d exp=5", sel); end
  endtask

  task automatic test_reset_mid_edit;
    btn_up = 1'b0; tick(6);
    total++; if (sel !== 3'd5 || blank !== 1'b0) begin bad++; $display("FAIL idle_wake sel=%0d blank=%b exp 5/0", sel, blank); end
    btn_up = 1'b1; tick(6);
    for (int i = 4; i >= 3; i--) begin
      btn_down = 1'b0; tick(6);
      total++; if (sel !== 3'(i)) begin bad++; $display("FAIL down_to_3 sel=%0d exp=%0d", sel, i); end
      btn_down = 1'b1; tick(6);
    end
    btn_up = 1'b0;
    tick(3);
    reset = 1'b1;
    #1;
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL async_sel got=%0d exp=0", sel); end
    total++; if (value !== 3'd0) begin bad++; $display("FAIL async_value got=%0d exp=0", value); end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL async_blank got=%b exp=1", blank); end
    total++; if (confirmed !== 1'b0) begin bad++; $display("FAIL async_conf got=%b exp=0", confirmed); end
    tick(2);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 5) begin
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL rst_rewake_early blank=%b exp=1", blank); end
      end
      if (k == 6) begin
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL rst_rewake blank=%b exp=0", blank); end
      end
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL no_repeat cyc=%0d sel=%0d exp=0", k, sel); end
    end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL held_timeout blank=%b exp=1", blank); end
    btn_up = 1'b1;
    tick(6);
  endtask

  initial begin
    test_reset();
    test_glitch_wake();
    test_step();
    test_confirm();
    test_timeout();
    test_reset_mid_edit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
